// File: rtl/system_cpu_jtag_ocimem.sv
// JTAG debug on-chip memory controller: queues monitor reads/writes
// from the debug module and shares a single-port RAM with an Avalon-MM slave.
module system_cpu_jtag_ocimem #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  input  logic [3:0]        avs_byteenable,
  output logic [31:0]       avs_readdata,
  output logic              avs_waitrequest
);

  typedef enum logic [1:0] {
    IDLE,
    J_RD,
    C_RD
  } state_t;

  state_t state;

  logic [ADDR_W-1:0] mon_a_reg;
  logic              pend_valid;
  logic              pend_write;
  logic [31:0]       pend_data;

  logic [31:0]       mem [0:(1<<ADDR_W)-1];
  logic [31:0]       ram_q;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wd;
  logic [3:0]        ram_be;
  logic              ram_we;
  logic              ram_re;

  logic jtag_go;
  logic cpu_rd_go;
  logic cpu_wr_go;
  logic cpu_done;

  logic [15:0] jaddr;
  logic        range_bad;
  logic        any_strobe;
  logic        busy;
  logic        accept;
  logic        win_a;
  logic        win_na;
  logic        lose;
  logic        err_set;
  logic        err_clr;
  logic        unused_jdo;

  assign unused_jdo = ^{jdo[37:36], jdo[1:0]};

  // Arbiter: a queued JTAG op always wins the port over the CPU in IDLE
  assign jtag_go   = (state == IDLE) && pend_valid;
  assign cpu_rd_go = (state == IDLE) && !pend_valid && avs_read;
  assign cpu_wr_go = (state == IDLE) && !pend_valid && !avs_read
                     && avs_write;
  assign cpu_done  = (state == C_RD) || cpu_wr_go;

  assign ram_addr = jtag_go ? mon_a_reg : avs_address;
  assign ram_wd   = jtag_go ? pend_data : avs_writedata;
  assign ram_be   = jtag_go ? 4'hf : avs_byteenable;
  assign ram_we   = (jtag_go && pend_write) || cpu_wr_go;
  assign ram_re   = (jtag_go && !pend_write) || cpu_rd_go;

  assign avs_readdata    = (state == C_RD) ? ram_q : 32'h0;
  assign avs_waitrequest = !reset && (avs_read || avs_write)
                           && !cpu_done;

  assign jaddr      = jdo[17:2];
  assign range_bad  = (jaddr >> ADDR_W) != 16'h0;
  assign any_strobe = take_action_ocimem_a | take_no_action_ocimem_a
                      | take_action_ocimem_b;
  assign busy       = pend_valid || (state == J_RD);
  assign accept     = any_strobe && !busy;
  assign win_a      = take_action_ocimem_a && !take_action_ocimem_b;
  assign win_na     = take_no_action_ocimem_a && !take_action_ocimem_a
                      && !take_action_ocimem_b;
  assign lose       = (take_action_ocimem_b && (take_action_ocimem_a
                       || take_no_action_ocimem_a))
                      || (take_action_ocimem_a && take_no_action_ocimem_a);
  assign err_set    = lose || (any_strobe && busy)
                      || (accept && win_a && range_bad);
  assign err_clr    = accept && win_a && jdo[34];

  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (ram_be[i]) mem[ram_addr][8*i +: 8] <= ram_wd[8*i +: 8];
      end
    end
    if (ram_re) ram_q <= mem[ram_addr];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      mon_a_reg     <= '0;
      pend_valid    <= 1'b0;
      pend_write    <= 1'b0;
      pend_data     <= 32'h0;
      MonDReg       <= 32'h0;
      monitor_ready <= 1'b0;
      monitor_error <= 1'b0;
    end else begin
      if (jtag_go) pend_valid <= 1'b0;

      // Accepted strobes never coincide with a completion (busy blocks them)
      if (accept) begin
        unique case (1'b1)
          take_action_ocimem_b: begin
            pend_valid <= 1'b1;
            pend_write <= 1'b1;
            pend_data  <= jdo[34:3];
          end
          win_a: begin
            monitor_ready <= 1'b0;
            mon_a_reg     <= jdo[ADDR_W+1:2];
            if (!range_bad && jdo[35]) begin
              pend_valid <= 1'b1;
              pend_write <= 1'b0;
            end
          end
          win_na: begin
            pend_valid <= 1'b1;
            pend_write <= 1'b0;
          end
          default: ;
        endcase
      end

      if (err_set) monitor_error <= 1'b1;
      else if (err_clr) monitor_error <= 1'b0;

      unique case (state)
        IDLE: begin
          if (jtag_go) begin
            if (pend_write) begin
              monitor_ready <= 1'b1;
              mon_a_reg     <= mon_a_reg + 1'b1;
            end else begin
              state <= J_RD;
            end
          end else if (cpu_rd_go) begin
            state <= C_RD;
          end
        end
        J_RD: begin
          MonDReg       <= ram_q;
          monitor_ready <= 1'b1;
          mon_a_reg     <= mon_a_reg + 1'b1;
          state         <= IDLE;
        end
        C_RD: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_system_cpu_jtag_ocimem.sv
// Directed bench for system_cpu_jtag_ocimem: JTAG reads/writes,
// wrap, range error, CPU contention, overrun and async reset.
module tb_system_cpu_jtag_ocimem;

  logic        clk;
  logic        reset;
  logic [37:0] jdo;
  logic        take_action_ocimem_a;
  logic        take_no_action_ocimem_a;
  logic        take_action_ocimem_b;
  logic [31:0] MonDReg;
  logic        monitor_ready;
  logic        monitor_error;
  logic [7:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [3:0]  avs_byteenable;
  logic [31:0] avs_readdata;
  logic        avs_waitrequest;

  int tests;
  int fails;

  system_cpu_jtag_ocimem #(.ADDR_W(8)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error),
    .avs_address             (avs_address),
    .avs_read                (avs_read),
    .avs_write               (avs_write),
    .avs_writedata           (avs_writedata),
    .avs_byteenable          (avs_byteenable),
    .avs_readdata            (avs_readdata),
    .avs_waitrequest         (avs_waitrequest)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic jtag_a(input logic [15:0] a, input logic rd,
                        input logic clr);
    jdo = '0;
    jdo[17:2] = a;
    jdo[34] = clr;
    jdo[35] = rd;
    take_action_ocimem_a = 1'b1;
    tick();
    take_action_ocimem_a = 1'b0;
    jdo = '0;
  endtask

  task automatic jtag_b(input logic [31:0] d);
    jdo = '0;
    jdo[34:3] = d;
    take_action_ocimem_b = 1'b1;
    tick();
    take_action_ocimem_b = 1'b0;
    jdo = '0;
  endtask

  task automatic jtag_na();
    take_no_action_ocimem_a = 1'b1;
    tick();
    take_no_action_ocimem_a = 1'b0;
  endtask

  task automatic cpu_write(input logic [7:0] a, input logic [31:0] d,
                           input logic [3:0] be);
    avs_address = a;
    avs_writedata = d;
    avs_byteenable = be;
    avs_write = 1'b1;
    tick();
    avs_write = 1'b0;
  endtask

  task automatic test_reset();
    tests++;
    if ({MonDReg, monitor_ready, monitor_error} !== 34'h0) begin
      fails++;
      $display("FAIL reset_mon: got %h %b %b want 0 0 0",
               MonDReg, monitor_ready, monitor_error);
    end
    tests++;
    if ({avs_readdata, avs_waitrequest} !== 33'h0) begin
      fails++;
      $display("FAIL reset_avs: got %h %b want 0 0",
               avs_readdata, avs_waitrequest);
    end
  endtask

  task automatic test_write_read();
    jtag_a(16'd5, 1'b0, 1'b0);
    jtag_b(32'hDEADBEEF);
    tick();
    tests++;
    if (monitor_ready !== 1'b1 || dut.mon_a_reg !== 8'd6) begin
      fails++;
      $display("FAIL wr_done: got rdy=%b areg=%0d want 1 6",
               monitor_ready, dut.mon_a_reg);
    end
    jtag_a(16'd5, 1'b1, 1'b0);
    tests++;
    if (monitor_ready !== 1'b0) begin
      fails++;
      $display("FAIL rd_n1: got rdy=%b want 0", monitor_ready);
    end
    tick();
    tests++;
    if (monitor_ready !== 1'b0) begin
      fails++;
      $display("FAIL rd_n2: got rdy=%b want 0", monitor_ready);
    end
    tick();
    tests++;
    if (monitor_ready !== 1'b1 || MonDReg !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL rd_n3: got rdy=%b d=%h want 1 deadbeef",
               monitor_ready, MonDReg);
    end
  endtask

  task automatic test_stream_wrap();
    jtag_a(16'd255, 1'b0, 1'b0);
    jtag_b(32'h11111111);
    tick();
    jtag_b(32'h22222222);
    tick();
    jtag_a(16'd255, 1'b1, 1'b0);
    tick();
    tick();
    tests++;
    if (MonDReg !== 32'h11111111 || dut.mon_a_reg !== 8'd0) begin
      fails++;
      $display("FAIL stream_255: got d=%h areg=%0d want 11111111 0",
               MonDReg, dut.mon_a_reg);
    end
    jtag_na();
    tick();
    tick();
    tests++;
    if (MonDReg !== 32'h22222222 || dut.mon_a_reg !== 8'd1
        || monitor_ready !== 1'b1) begin
      fails++;
      $display("FAIL stream_wrap: got d=%h areg=%0d rdy=%b want 22222222 1 1",
               MonDReg, dut.mon_a_reg, monitor_ready);
    end
  endtask

  task automatic test_range_error();
    jtag_a(16'h0100, 1'b1, 1'b0);
    tests++;
    if (monitor_error !== 1'b1 || monitor_ready !== 1'b0) begin
      fails++;
      $display("FAIL range_set: got err=%b rdy=%b want 1 0",
               monitor_error, monitor_ready);
    end
    tick();
    tick();
    tick();
    tests++;
    if (monitor_ready !== 1'b0 || MonDReg !== 32'h22222222) begin
      fails++;
      $display("FAIL range_noread: got rdy=%b d=%h want 0 22222222",
               monitor_ready, MonDReg);
    end
    jtag_a(16'h0200, 1'b0, 1'b1);
    tests++;
    if (monitor_error !== 1'b1) begin
      fails++;
      $display("FAIL err_precedence: got err=%b want 1", monitor_error);
    end
    jtag_a(16'd3, 1'b0, 1'b1);
    tests++;
    if (monitor_error !== 1'b0 || dut.mon_a_reg !== 8'd3) begin
      fails++;
      $display("FAIL err_clear: got err=%b areg=%0d want 0 3",
               monitor_error, dut.mon_a_reg);
    end
  endtask

  task automatic test_cpu_access();
    cpu_write(8'd7, 32'hCAFEF00D, 4'hf);
    avs_address = 8'd7;
    avs_writedata = 32'h0000AA00;
    avs_byteenable = 4'b0010;
    avs_write = 1'b1;
    #1;
    tests++;
    if (avs_waitrequest !== 1'b0) begin
      fails++;
      $display("FAIL cpu_wr_wait: got %b want 0", avs_waitrequest);
    end
    tick();
    avs_write = 1'b0;
    avs_address = 8'd7;
    avs_read = 1'b1;
    #1;
    tests++;
    if (avs_waitrequest !== 1'b1) begin
      fails++;
      $display("FAIL cpu_rd_c1: got wait=%b want 1", avs_waitrequest);
    end
    tick();
    tests++;
    if (avs_waitrequest !== 1'b0 || avs_readdata !== 32'hCAFEAA0D) begin
      fails++;
      $display("FAIL cpu_rd_c2: got wait=%b d=%h want 0 cafeaa0d",
               avs_waitrequest, avs_readdata);
    end
    tick();
    avs_read = 1'b0;
  endtask

  task automatic test_contention();
    int waits;
    waits = 0;
    jtag_a(16'd7, 1'b1, 1'b0);
    avs_address = 8'd7;
    avs_read = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      if (avs_waitrequest === 1'b1) waits++;
      tick();
    end
    tests++;
    if (waits !== 3) begin
      fails++;
      $display("FAIL cont_wait: got %0d stall cycles want 3", waits);
    end
    tests++;
    if (avs_waitrequest !== 1'b0 || avs_readdata !== 32'hCAFEAA0D) begin
      fails++;
      $display("FAIL cont_data: got wait=%b d=%h want 0 cafeaa0d",
               avs_waitrequest, avs_readdata);
    end
    tests++;
    if (MonDReg !== 32'hCAFEAA0D || monitor_ready !== 1'b1) begin
      fails++;
      $display("FAIL cont_jtag: got d=%h rdy=%b want cafeaa0d 1",
               MonDReg, monitor_ready);
    end
    tick();
    avs_read = 1'b0;
  endtask

  task automatic test_back_to_back();
    cpu_write(8'd21, 32'h0, 4'hf);
    jtag_a(16'd20, 1'b0, 1'b0);
    jtag_b(32'h12345678);
    jtag_b(32'h9ABCDEF0);
    tests++;
    if (monitor_error !== 1'b1 || dut.mon_a_reg !== 8'd21) begin
      fails++;
      $display("FAIL overrun_err: got err=%b areg=%0d want 1 21",
               monitor_error, dut.mon_a_reg);
    end
    jtag_a(16'd20, 1'b1, 1'b0);
    tick();
    tick();
    tests++;
    if (MonDReg !== 32'h12345678 || monitor_error !== 1'b1) begin
      fails++;
      $display("FAIL overrun_first: got d=%h err=%b want 12345678 1",
               MonDReg, monitor_error);
    end
    avs_address = 8'd21;
    avs_read = 1'b1;
    tick();
    tests++;
    if (avs_readdata !== 32'h0) begin
      fails++;
      $display("FAIL overrun_drop: got %h want 0", avs_readdata);
    end
    tick();
    avs_read = 1'b0;
  endtask

  task automatic test_simultaneous();
    jtag_a(16'd30, 1'b0, 1'b1);
    jdo = '0;
    jdo[34:3] = 32'h0F0F0F0F;
    take_action_ocimem_b = 1'b1;
    take_no_action_ocimem_a = 1'b1;
    tick();
    take_action_ocimem_b = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    jdo = '0;
    tick();
    tests++;
    if (monitor_error !== 1'b1 || monitor_ready !== 1'b1
        || dut.mon_a_reg !== 8'd31) begin
      fails++;
      $display("FAIL simul: got err=%b rdy=%b areg=%0d want 1 1 31",
               monitor_error, monitor_ready, dut.mon_a_reg);
    end
    avs_address = 8'd30;
    avs_read = 1'b1;
    tick();
    tests++;
    if (avs_readdata !== 32'h0F0F0F0F) begin
      fails++;
      $display("FAIL simul_data: got %h want 0f0f0f0f", avs_readdata);
    end
    tick();
    avs_read = 1'b0;
  endtask

  task automatic test_reset_mid_read();
    avs_address = 8'd0;
    avs_read = 1'b1;
    tick();
    tests++;
    if (avs_readdata !== 32'h22222222) begin
      fails++;
      $display("FAIL pre_reset: got %h want 22222222", avs_readdata);
    end
    reset = 1'b1;
    #1;
    tests++;
    if ({MonDReg, monitor_ready, monitor_error} !== 34'h0
        || {avs_readdata, avs_waitrequest} !== 33'h0) begin
      fails++;
      $display("FAIL async_reset: got %h %b %b %h %b want all 0",
               MonDReg, monitor_ready, monitor_error,
               avs_readdata, avs_waitrequest);
    end
    avs_read = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    avs_address = 8'd0;
    avs_read = 1'b1;
    #1;
    tests++;
    if (avs_waitrequest !== 1'b1) begin
      fails++;
      $display("FAIL post_reset_c1: got wait=%b want 1", avs_waitrequest);
    end
    tick();
    tests++;
    if (avs_waitrequest !== 1'b0 || avs_readdata !== 32'h22222222) begin
      fails++;
      $display("FAIL post_reset_c2: got wait=%b d=%h want 0 22222222",
               avs_waitrequest, avs_readdata);
    end
    tick();
    avs_read = 1'b0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    jdo = '0;
    take_action_ocimem_a = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    take_action_ocimem_b = 1'b0;
    avs_address = '0;
    avs_read = 1'b0;
    avs_write = 1'b0;
    avs_writedata = '0;
    avs_byteenable = '0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    test_reset();
    test_write_read();
    test_stream_wrap();
    test_range_error();
    test_cpu_access();
    test_contention();
    test_back_to_back();
    test_simultaneous();
    test_reset_mid_read();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/system_cpu_jtag_ocimem.md
# system_cpu_jtag_ocimem

Debug-side on-chip memory controller for the Nios II JTAG debug module. It consumes the clk-domain command strobes and 38-bit `jdo` payload produced by the debug module's system-clock stage. It executes monitor reads and writes against a single-port debug RAM, which the CPU also reaches through an Avalon-MM slave. It returns `MonDReg`, `monitor_ready` and `monitor_error` to the JTAG shift path.

## Interface
- `ADDR_W`, 8: debug RAM word-address width; depth = 2^ADDR_W words of 32 bits.
- `clk`  in  1  single system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `jdo`  in  38  JTAG command payload; sampled only in cycles where a strobe is high.
- `take_action_ocimem_a`  in  1  one-cycle strobe: load address, optional read, optional error clear.
- `take_no_action_ocimem_a`  in  1  one-cycle strobe: streaming read at current address.
- `take_action_ocimem_b`  in  1  one-cycle strobe: write at current address.
- `MonDReg`  out  32  last JTAG read data.
- `monitor_ready`  out  1  last JTAG operation complete.
- `monitor_error`  out  1  sticky error flag.
- `avs_address`  in  ADDR_W  CPU word address.
- `avs_read` / `avs_write`  in  1  CPU request.
- `avs_writedata`  in  32  CPU write data.
- `avs_byteenable`  in  4  CPU byte lanes.
- `avs_readdata`  out  32  CPU read data; valid when `avs_read` is high and `avs_waitrequest` is low.
- `avs_waitrequest`  out  1  CPU stall.

## Operation
- **jdo fields**
  - Address: `jdo[17:2]`.
  - Write data: `jdo[34:3]`.
  - Clear-error bit: `jdo[34]` (ocimem_a only).
  - Read-start bit: `jdo[35]` (ocimem_a only).
- **take_action_ocimem_a**
  - Clears `monitor_ready`.
  - Loads `MonAReg <= jdo[ADDR_W+1:2]`.
  - If `jdo[34]`, clears `monitor_error`.
  - If any bit of `jdo[17:ADDR_W+2]` is nonzero: sets `monitor_error` and queues no read.
  - Otherwise, if `jdo[35]`, queues a JTAG read.
- **take_no_action_ocimem_a**: queues a JTAG read at `MonAReg`.
- **take_action_ocimem_b**: queues a JTAG write of `jdo[34:3]` (all 4 byte lanes) at `MonAReg`.
- **Command queue**
  - One-deep pending register holds the queued operation.
  - A strobe arriving while an operation is pending or in flight sets `monitor_error` and is dropped. Existing state is unchanged.
- **Completion**
  - JTAG read: `MonDReg <= RAM data`.
  - Read or write: `monitor_ready <= 1` and `MonAReg` increments, wrapping from 2^ADDR_W−1 to 0.
- **Arbiter**
  - JTAG pending has priority over CPU for the RAM port.
  - A CPU request loses only in cycles where JTAG issues.
- **FSM**
  - IDLE:
    - JTAG pending → issue the RAM access.
      - Read goes to J_RD.
      - Write completes in the issue cycle and stays in IDLE.
    - Else `avs_read` → issue, go to C_RD.
    - Else `avs_write` → byte-masked write in that cycle, `avs_waitrequest` low, stay in IDLE.
  - J_RD: capture RAM data into `MonDReg`, go to IDLE.
  - C_RD: drive `avs_readdata` = RAM data, `avs_waitrequest` low, go to IDLE.
- `avs_waitrequest` is high whenever `avs_read` or `avs_write` is high and the request does not complete in this cycle.

## Timing
- **Reset values**: `MonDReg` = 0, `monitor_ready` = 0, `monitor_error` = 0, `MonAReg` = 0, pending empty, FSM = IDLE, `avs_readdata` = 0, `avs_waitrequest` = 0. RAM contents are not reset.
- **RAM**: synchronous read, 1-cycle latency.
- **JTAG latency** (strobe at cycle N, no CPU contention)
  - Pending at N+1.
  - Write: RAM written and `monitor_ready` high at N+2.
  - Read: issued at N+1, `MonDReg` and `monitor_ready` updated at N+3.
- **CPU read**: minimum 2 cycles, with `avs_waitrequest` high in the first. CPU write: minimum 1 cycle.
- **Contention**: a JTAG issue in a cycle where the CPU is requesting stalls the CPU ≥1 extra cycle. A C_RD already in progress is never preempted.
- **Simultaneous strobes**
  - Priority: ocimem_b > ocimem_a > no_action_a.
  - The losing strobes set `monitor_error`.
- **Error-flag precedence**: a clear via `jdo[34]` and a new error event in the same cycle leave `monitor_error` = 1.
- **Reset mid-operation**: reset asserted during J_RD or C_RD aborts the access immediately; outputs return to reset values asynchronously.

## Test plan
- **Reset**: assert reset mid-C_RD → all outputs read 0 immediately; after release, an `avs_read` of address 0 completes in 2 cycles.
- **JTAG write then read**
  - ocimem_a with address 5, `jdo[35]` = 0; then ocimem_b with data 0xDEADBEEF → RAM[5] = 0xDEADBEEF and `MonAReg` = 6.
  - ocimem_a with address 5, `jdo[35]` = 1 → `MonDReg` = 0xDEADBEEF and `monitor_ready` = 1 exactly 3 cycles after the strobe.
- **Streaming read with wrap**: address 255 (`ADDR_W` = 8), read, then no_action_a → second read returns RAM[0] and `MonAReg` = 1.
- **Range error**: ocimem_a with `jdo[17:2]` = 0x0100 → `monitor_error` = 1 and no RAM access. Next ocimem_a with `jdo[34]` = 1 and a valid address → `monitor_error` = 0.
- **Contention**: CPU `avs_read` and JTAG pending in the same cycle → JTAG issues first; CPU sees `avs_waitrequest` high for 3 cycles, then correct data.
- **Overrun**: two ocimem_b strobes 1 cycle apart → first write lands, second is dropped, `monitor_error` = 1.
